// File: rtl/jtkicker_pkg.sv
// Shared types and constants for the kicker graphics ROM slots.
// Holds the slot FSM states, the default SDRAM address width and the ROM region bases.
package jtkicker_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        BEAT0 = 2'd2,
        BEAT1 = 2'd3
    } slot_state_t;

    localparam int SDW_DEF = 22;

    // SDRAM base addresses (16-bit words) of each graphics ROM region
    localparam logic [SDW_DEF-1:0] MAIN_OFFSET = 22'h000000;
    localparam logic [SDW_DEF-1:0] SCR_OFFSET  = 22'h010000;
    localparam logic [SDW_DEF-1:0] OBJ_OFFSET  = 22'h018000;
    localparam logic [SDW_DEF-1:0] PROM_OFFSET = 22'h020000;

endpackage

// File: rtl/jtkicker_romslot.sv
// Single-entry ROM slot: turns a missed 32-bit tile fetch into a two-beat
// 16-bit SDRAM burst and keeps the last fetched word as a one-entry cache.
module jtkicker_romslot
    import jtkicker_pkg::*;
#(
    parameter int             AW     = 13,
    parameter int             SDW    = SDW_DEF,
    parameter logic [SDW-1:0] OFFSET = '0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           slot_cs,
    input  logic [AW-1:0]  slot_addr,
    output logic [31:0]    slot_dout,
    output logic           slot_ok,
    output logic [SDW-1:0] sdram_addr,
    output logic           sdram_req,
    input  logic           sdram_ack,
    input  logic           data_dst,
    input  logic           data_rdy,
    input  logic [15:0]    data_read
);

    slot_state_t   state, state_nxt;
    logic [AW-1:0] tag;
    logic [AW-1:0] fetch_addr;
    logic          valid;
    logic [31:0]   data;
    logic          beat;
    logic          start_fetch;

    assign beat       = data_dst & data_rdy;
    assign slot_ok    = valid & slot_cs & (tag == slot_addr);
    assign slot_dout  = data;
    // Word address doubled for 16-bit SDRAM words; the sum wraps modulo 2^SDW
    assign sdram_addr = OFFSET + SDW'({fetch_addr, 1'b0});

    always_comb begin
        state_nxt   = state;
        start_fetch = 1'b0;
        sdram_req   = 1'b0;
        case (state)
            IDLE: begin
                if (slot_cs && !slot_ok) begin
                    start_fetch = 1'b1;
                    state_nxt   = REQ;
                end
            end
            REQ: begin
                sdram_req = 1'b1;
                if (sdram_ack) state_nxt = BEAT0;
            end
            BEAT0: begin
                if (beat) state_nxt = BEAT1;
            end
            BEAT1: begin
                if (beat) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A burst in flight always completes; the cache entry is tagged with the
    // address that launched it, not whatever the requester shows now
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            tag        <= '0;
            fetch_addr <= '0;
            valid      <= 1'b0;
            data       <= '0;
        end else begin
            state <= state_nxt;
            if (start_fetch) begin
                fetch_addr <= slot_addr;
                valid      <= 1'b0;
            end
            if (state == BEAT0 && beat) begin
                data[15:0] <= data_read;
            end
            if (state == BEAT1 && beat) begin
                data[31:16] <= data_read;
                tag         <= fetch_addr;
                valid       <= 1'b1;
            end
        end
    end

endmodule

// File: doc/jtkicker_romslot.md
# jtkicker_romslot

Single-entry ROM slot that answers the tile-fetch request protocol used by the kicker scroll and object layers (`rom_addr` / `rom_data` / `rom_ok`). It turns each missed 32-bit request into one two-beat 16-bit SDRAM burst and holds the last fetched word as a one-entry cache. It sits between one graphics layer and the SDRAM arbiter port in the game top level.

## Interface
Parameters:
- `AW`, 13: requester address width, in 32-bit words.
- `SDW`, 22: SDRAM word address width, in 16-bit words.
- `OFFSET`, 22'h0: SDRAM base address of this ROM region.

Ports:
- `clk`  in  1  48 MHz system clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `slot_cs`  in  1  requester active; no new fetch starts while low.
- `slot_addr`  in  AW  requested 32-bit word address.
- `slot_dout`  out  32  fetched data: beat 0 in [15:0], beat 1 in [31:16].
- `slot_ok`  out  1  `slot_dout` is valid for the current `slot_addr`.
- `sdram_addr`  out  SDW  burst start address.
- `sdram_req`  out  1  burst request; held until acknowledged.
- `sdram_ack`  in  1  arbiter accepted the request.
- `data_dst`  in  1  the current SDRAM beat belongs to this slot.
- `data_rdy`  in  1  a 16-bit beat is present on `data_read`.
- `data_read`  in  16  SDRAM read data.

## Operation
- Registers: `tag` (AW), `valid`, `data` (32), `fetch_addr` (AW), state.
- `slot_ok = valid & slot_cs & (tag == slot_addr)`. This is combinational, so it drops in the same cycle the address changes.
- `sdram_addr = OFFSET + {fetch_addr, 1'b0}`. Width is SDW and overflow wraps modulo 2^SDW.
- States:
  - IDLE: on `slot_cs & ~slot_ok`, latch `fetch_addr <= slot_addr`, set `sdram_req`, go to REQ.
  - REQ: hold `sdram_req` and `fetch_addr` stable. On `sdram_ack`, clear `sdram_req` and go to BEAT0.
  - BEAT0: on `data_dst & data_rdy`, write `data[15:0] <= data_read` and go to BEAT1.
  - BEAT1: on `data_dst & data_rdy`, write `data[31:16] <= data_read`, `tag <= fetch_addr`, `valid <= 1`, and go to IDLE.
- `valid` clears when a fetch starts (IDLE to REQ). Stale data is never flagged ok.
- A beat with `data_dst` low, or with `data_rdy` in IDLE or REQ, is ignored.
- Address change during REQ/BEAT0/BEAT1: the burst is not aborted. It completes and fills the cache under `fetch_addr`. `slot_ok` stays low because of the tag mismatch, and a new fetch starts from IDLE on the following cycle.
- `slot_cs` falling mid-fetch: the fetch completes normally; no new fetch starts.
- `slot_dout` is driven directly from `data`, whatever the value of `slot_ok`.

## Timing
- Reset values: `slot_ok` 0, `sdram_req` 0, `slot_dout` 0, `sdram_addr` = OFFSET, `valid` 0, `tag` 0, state IDLE.
- Miss latency, with the miss seen at cycle 0:
  - `sdram_req` rises at cycle 1.
  - Ack at cycle A takes the slot to BEAT0 at A+1.
  - The beat-1 capture edge is at cycle B.
  - `slot_ok` is high from B+1.
- Hit: `slot_ok` is high in the same cycle `slot_addr` matches the tag. There is no SDRAM activity.
- Back-to-back beats on consecutive cycles are accepted. Gaps of any length between beats are allowed.
- An address change in the same cycle as the beat-1 capture gives `slot_ok` low at B+1 and `sdram_req` high at B+2.
- `rst` asserted mid-burst returns the slot to IDLE and clears `valid`. Beats still arriving from the aborted burst are ignored because the state is IDLE.

## Structure
- Shared `jtkicker_pkg`:
  - the state enum (IDLE, REQ, BEAT0, BEAT1);
  - the `SDW` default;
  - the per-ROM OFFSET constants used by the top level.
- Single module. The tag compare and FSM are too small to split, so there is no sub-module.

## Test plan
- Reset then miss, with OFFSET=22'h10000 and `slot_addr`=13'h0A5:
  - `sdram_req` rises 1 cycle later with `sdram_addr`=22'h1014A.
  - Ack, then beats 16'h1234 and 16'hABCD, give `slot_dout`=32'hABCD1234 and `slot_ok`=1 the cycle after the second beat.
- Hit: re-present 13'h0A5 after a fetch of 13'h0A6 completed and then returning to 13'h0A5:
  - a new fetch is issued;
  - re-presenting 13'h0A5 after its own fill gives `slot_ok`=1 immediately with no `sdram_req`.
- Address change while in REQ (13'h010 to 13'h011):
  - the burst for 13'h010 completes with `slot_ok`=0;
  - a second request for 13'h011 follows, with `sdram_addr`=OFFSET+22'h22.
- Foreign beats: `data_rdy`=1 with `data_dst`=0 during BEAT0 leaves `data` unchanged and the state in BEAT0.
- `rst` pulse during BEAT1: the next cycle shows state IDLE, `slot_ok`=0 and `sdram_req`=0. A trailing beat is ignored.
- Wrap: OFFSET=22'h3FFFFE with `slot_addr`=13'h1 gives `sdram_addr`=22'h000000.
